// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the CCE microcode loader.
package bp_me_pkg;

  localparam int unsigned cce_instr_width_gp = 64;

  typedef enum logic [2:0] {
    e_ucl_reset      = 3'd0,
    e_ucl_idle       = 3'd1,
    e_ucl_write      = 3'd2,
    e_ucl_verify_rd  = 3'd3,
    e_ucl_verify_chk = 3'd4,
    e_ucl_done       = 3'd5,
    e_ucl_error      = 3'd6
  } bp_cce_ucode_loader_state_e;

  // Largest legal load size: one instruction per RAM entry.
  function automatic int unsigned ucl_max_count(input int unsigned pc_width);
    return 32'(1) << pc_width;
  endfunction

endpackage

// File: rtl/bp_cce_ucode_checksum.sv
// XOR accumulator used for the write-side and read-back checksums.
module bp_cce_ucode_checksum #(
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] sum_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      sum_o <= '0;
    end else if (en_i) begin
      sum_o <= sum_o ^ data_i;
    end
  end

endmodule

// File: rtl/bp_cce_ucode_loader.sv
// Streams microcode into the CCE ucode RAM from PC 0, holding the CCE halted until done.
// Define BP_CCE_UCODE_LOADER_VERIFY_EN to add XOR-checksum read-back verification.
module bp_cce_ucode_loader
  import bp_me_pkg::*;
#(
  parameter int unsigned cce_pc_width_p    = 8,
  parameter int unsigned cce_instr_width_p = cce_instr_width_gp
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [cce_pc_width_p:0]      count_i,
  input  logic [cce_instr_width_p-1:0] instr_data_i,
  input  logic                         instr_v_i,
  output logic                         instr_ready_and_o,
  output logic                         ucode_v_o,
  output logic                         ucode_w_o,
  output logic [cce_pc_width_p-1:0]    ucode_addr_o,
  output logic [cce_instr_width_p-1:0] ucode_data_o,
  input  logic [cce_instr_width_p-1:0] ucode_data_i,
  output logic                         cce_halt_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int unsigned cnt_width_lp = cce_pc_width_p + 1;
  localparam int unsigned max_count_lp = ucl_max_count(cce_pc_width_p);

  bp_cce_ucode_loader_state_e state_r, state_n;

  logic [cnt_width_lp-1:0] cnt_r;
  logic [cnt_width_lp-1:0] addr_r;
  logic start_accept, count_zero, count_over, wr_hs, wr_last;

  assign start_accept = start_i
                      & (state_r inside {e_ucl_idle, e_ucl_done, e_ucl_error});
  assign count_zero   = (count_i == '0);
  assign count_over   = (count_i > cnt_width_lp'(max_count_lp));
  assign wr_hs        = (state_r == e_ucl_write) & instr_v_i;
  assign wr_last      = wr_hs & (addr_r == (cnt_r - cnt_width_lp'(1)));

  // addr_r carries one extra bit so a full-depth load ends on 2^pc without reusing PC 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r  <= '0;
      addr_r <= '0;
    end else if (start_accept) begin
      cnt_r  <= count_i;
      addr_r <= '0;
    end else if (wr_hs) begin
      addr_r <= addr_r + cnt_width_lp'(1);
    end
  end

`ifdef BP_CCE_UCODE_LOADER_VERIFY_EN
  logic [cnt_width_lp-1:0]      rd_addr_r;
  logic                         rd_v_r;
  logic                         rd_issue, rd_last, chk_match;
  logic [cce_instr_width_p-1:0] csum_r, chk_r;

  assign rd_issue  = (state_r == e_ucl_verify_rd);
  assign rd_last   = rd_issue & (rd_addr_r == (cnt_r - cnt_width_lp'(1)));
  assign chk_match = ((chk_r ^ ucode_data_i) == csum_r);

  // Read data lags the issued read by one cycle; rd_v_r marks the cycles to fold it in.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_addr_r <= '0;
      rd_v_r    <= 1'b0;
    end else begin
      rd_v_r <= rd_issue;
      if (start_accept) begin
        rd_addr_r <= '0;
      end else if (rd_issue) begin
        rd_addr_r <= rd_addr_r + cnt_width_lp'(1);
      end
    end
  end

  bp_cce_ucode_checksum #(.width_p(cce_instr_width_p)) u_csum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_accept),
    .en_i    (wr_hs),
    .data_i  (instr_data_i),
    .sum_o   (csum_r)
  );

  bp_cce_ucode_checksum #(.width_p(cce_instr_width_p)) u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_accept),
    .en_i    (rd_v_r),
    .data_i  (ucode_data_i),
    .sum_o   (chk_r)
  );
`else
  logic unused_ucode_data;
  assign unused_ucode_data = ^ucode_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ucl_reset;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ucl_reset: state_n = e_ucl_idle;
      e_ucl_idle, e_ucl_done, e_ucl_error: begin
        if (start_i) begin
          if (count_zero)      state_n = e_ucl_done;
          else if (count_over) state_n = e_ucl_error;
          else                 state_n = e_ucl_write;
        end
      end
      e_ucl_write: begin
`ifdef BP_CCE_UCODE_LOADER_VERIFY_EN
        if (wr_last) state_n = e_ucl_verify_rd;
`else
        if (wr_last) state_n = e_ucl_done;
`endif
      end
`ifdef BP_CCE_UCODE_LOADER_VERIFY_EN
      e_ucl_verify_rd: begin
        if (rd_last) state_n = e_ucl_verify_chk;
      end
      e_ucl_verify_chk: state_n = chk_match ? e_ucl_done : e_ucl_error;
`endif
      default: state_n = e_ucl_reset;
    endcase
  end

  // Write-path valid/data pass straight through so the stream runs at one beat per cycle.
  always_comb begin
    instr_ready_and_o = 1'b0;
    ucode_v_o         = 1'b0;
    ucode_w_o         = 1'b0;
    ucode_addr_o      = '0;
    ucode_data_o      = '0;
    cce_halt_o        = 1'b1;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    error_o           = 1'b0;
    case (state_r)
      e_ucl_write: begin
        instr_ready_and_o = 1'b1;
        ucode_v_o         = instr_v_i;
        ucode_w_o         = 1'b1;
        ucode_addr_o      = addr_r[cce_pc_width_p-1:0];
        ucode_data_o      = instr_data_i;
        busy_o            = 1'b1;
      end
`ifdef BP_CCE_UCODE_LOADER_VERIFY_EN
      e_ucl_verify_rd: begin
        ucode_v_o    = 1'b1;
        ucode_addr_o = rd_addr_r[cce_pc_width_p-1:0];
        busy_o       = 1'b1;
      end
      e_ucl_verify_chk: busy_o = 1'b1;
`endif
      e_ucl_done: begin
        done_o     = 1'b1;
        cce_halt_o = 1'b0;
      end
      e_ucl_error: error_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/bp_cce_ucode_loader.md
# bp_cce_ucode_loader

Sequencing controller for the CCE microcode RAM programming port. It accepts a ready&valid stream of microcode instructions, writes them to consecutive PCs starting at 0, and holds the CCE halted until the load completes. When configured in, it then reads the RAM back and compares an XOR checksum. It sits between the configuration/boot path and the CCE wrapper's ucode_v/w/addr/data ports.

## Interface
Parameters:
- cce_pc_width_p, 8, microcode PC width; RAM depth is 2^cce_pc_width_p.
- cce_instr_width_p, 64, instruction width; must equal cce_instr_width_gp.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- count_i  in  cce_pc_width_p+1  number of instructions to load. Sampled when start_i is accepted.
- instr_data_i  in  cce_instr_width_p  instruction stream data.
- instr_v_i  in  1  stream valid.
- instr_ready_and_o  out  1  stream ready; the handshake is ready&valid.
- ucode_v_o  out  1  RAM access valid.
- ucode_w_o  out  1  1 = write, 0 = read.
- ucode_addr_o  out  cce_pc_width_p  RAM address.
- ucode_data_o  out  cce_instr_width_p  write data.
- ucode_data_i  in  cce_instr_width_p  read data; valid the cycle after a read is issued.
- cce_halt_o  out  1  holds the CCE out of execution.
- busy_o  out  1  a load or verify is in progress.
- done_o  out  1  the last load succeeded.
- error_o  out  1  the last load failed.

## Operation
- States: RESET → IDLE → WRITE → (VERIFY_RD → VERIFY_CHK) → DONE | ERROR.
- Start handling:
  - start_i is accepted in IDLE, DONE or ERROR. Accepting it clears done_o and error_o, sets addr_r=0, sets csum_r=0, and latches cnt_r=count_i.
  - count_i==0 → DONE next cycle, with no RAM access.
  - count_i > 2^cce_pc_width_p → ERROR next cycle.
  - start_i in any other state is ignored.
- WRITE state:
  - instr_ready_and_o=1.
  - ucode_v_o=instr_v_i, ucode_w_o=1, ucode_addr_o=addr_r[cce_pc_width_p-1:0], ucode_data_o=instr_data_i.
  - On handshake: addr_r++ and csum_r ^= instr_data_i.
  - When the handshake with addr_r==cnt_r-1 occurs: → VERIFY_RD if verify is enabled, else → DONE.
  - A stream bubble (instr_v_i=0) stalls WRITE indefinitely. There is no timeout.
- VERIFY_RD state:
  - One read per cycle: ucode_v_o=1, ucode_w_o=0, ucode_addr_o=rd_addr_r, rd_addr_r++.
  - rd_v_r registers "read issued"; on each cycle where rd_v_r=1, chk_r ^= ucode_data_i.
  - After issuing read cnt_r-1 → VERIFY_CHK.
- VERIFY_CHK state:
  - Folds in the final read data.
  - If (chk_r ^ ucode_data_i)==csum_r → DONE, else → ERROR.
- DONE: done_o=1, cce_halt_o=0.
- ERROR: error_o=1, cce_halt_o=1.
- cce_halt_o is 1 in every state except DONE.
- busy_o=1 in WRITE, VERIFY_RD and VERIFY_CHK.
- ucode_v_o=0 in all states other than WRITE and VERIFY_RD.

## Timing
- Reset values: state=RESET, instr_ready_and_o=0, ucode_v_o=0, ucode_w_o=0, ucode_addr_o=0, ucode_data_o=0, cce_halt_o=1, busy_o=0, done_o=0, error_o=0. RESET → IDLE unconditionally on the first cycle after reset deasserts.
- Reset asserted mid-load aborts the load; the next cycle shows the reset values. RAM contents are then undefined; reloading is software's responsibility.
- start_i accepted in cycle t: WRITE is entered at t+1 and the first write may occur at t+1.
- Throughput is 1 instruction/cycle. N instructions with no bubbles give writes in cycles t+1..t+N.
- Without verify: done_o rises at t+N+1.
- With verify: reads are issued in t+N+1..t+2N and VERIFY_CHK occupies t+2N+1, so done_o or error_o rises at t+2N+2.
- count_i = 2^cce_pc_width_p: addr_r wraps its low bits to 0 only after the final write. No address is reused.
- All outputs except ucode_v_o and ucode_data_o in WRITE are decoded from registered state. In WRITE, ucode_v_o and ucode_data_o pass through combinationally from instr_v_i and instr_data_i.

## Configuration
- BP_CCE_UCODE_LOADER_VERIFY_EN defined:
  - VERIFY_RD and VERIFY_CHK states, rd_addr_r, rd_v_r, chk_r and csum_r are present.
  - Checksum mismatch → ERROR.
- Undefined:
  - The verify states, registers and comparator are compiled out.
  - WRITE → DONE directly.
  - error_o is asserted only for an oversize count_i.

## Structure
- bp_me_pkg holds:
  - the state enum bp_cce_ucode_loader_state_e (e_ucl_reset, e_ucl_idle, e_ucl_write, e_ucl_verify_rd, e_ucl_verify_chk, e_ucl_done, e_ucl_error);
  - a constant for the maximum count derived from cce_pc_width_p.
- One natural sub-module: bp_cce_ucode_checksum. It is an XOR accumulator with clear, en and data inputs and is instantiated once for csum_r and once for chk_r.
- Everything else is flat FSM and counters.

## Test plan
- Reset, then start_i with count_i=4 and data 0x11, 0x22, 0x33, 0x44 streamed without bubbles → writes to addr 0..3 in 4 consecutive cycles; done_o and cce_halt_o=0 at the cycle-count above.
- count_i=3 with instr_v_i deasserted for 5 cycles after the second beat → ucode_v_o=0 during the bubble; addr resumes at 2; done after the third write.
- With VERIFY_EN, the RAM model corrupts addr 1 (bit 0 flipped) on read-back → error_o=1, cce_halt_o=1, done_o=0.
- count_i=0 → done_o next cycle with no ucode_v_o pulses; count_i=257 with cce_pc_width_p=8 → error_o next cycle.
- count_i=256 → addresses 0..255 written; ucode_addr_o never repeats; done_o asserted.
- reset_i asserted after 2 of 4 writes → outputs return to reset values next cycle; a subsequent start_i with count_i=2 completes normally.
